// File: rtl/mac_scheduler.sv
// Shared MAC scheduler: arbitrates filter-stage requesters onto one signed multiply-accumulator.
// Define MAC_SCHED_FIXED_PRIO_EN for fixed-priority arbitration; round-robin otherwise.
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and latches the winner's burst length
// MAC    | one tap accumulated per cycle for the granted requester
// DONE   | publishes result, pulses done to the owner, releases the grant
module mac_scheduler #(
    parameter int NUM_REQ     = 3,
    parameter int INPUT_WIDTH = 50,
    parameter int COEFF_WIDTH = 18,
    parameter int MAX_TAPS    = 16,
    localparam int TAP_W      = $clog2(MAX_TAPS + 1),
    localparam int ACC_WIDTH  = INPUT_WIDTH + COEFF_WIDTH + TAP_W
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_i,
    input  logic [NUM_REQ*TAP_W-1:0]           len_i,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0]     smp_i,
    input  logic [NUM_REQ*COEFF_WIDTH-1:0]     coef_i,
    output logic [NUM_REQ-1:0]                 grant_o,
    output logic [TAP_W-1:0]                   tap_idx_o,
    output logic [NUM_REQ-1:0]                 done_o,
    output logic [ACC_WIDTH-1:0]               result_o,
    output logic                               busy_o
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PROD_W = INPUT_WIDTH + COEFF_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    state_t                        state;
    logic [IDX_W-1:0]              owner_q;
    logic [TAP_W-1:0]              len_q;
    logic signed [ACC_WIDTH-1:0]   acc;

    logic [IDX_W-1:0]              win_idx;
    logic                          win_vld;
    logic [NUM_REQ-1:0]            win_onehot;
    logic [TAP_W-1:0]              len_raw;
    logic [TAP_W-1:0]              len_win;

    logic signed [INPUT_WIDTH-1:0] smp_sel;
    logic signed [COEFF_WIDTH-1:0] coef_sel;
    logic signed [PROD_W-1:0]      prod;

`ifndef MAC_SCHED_FIXED_PRIO_EN
    logic [IDX_W-1:0]              rr_ptr;
    int                            cand;
`endif

    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
`ifdef MAC_SCHED_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                win_idx = IDX_W'(i);
                win_vld = 1'b1;
            end
        end
`else
        cand = 0;
        // Search begins one past the last winner so every requester gets a turn.
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ)
                cand = cand - NUM_REQ;
            if (!win_vld && req_i[IDX_W'(cand)]) begin
                win_idx = IDX_W'(cand);
                win_vld = 1'b1;
            end
        end
`endif
        win_onehot          = '0;
        win_onehot[win_idx] = win_vld;
        len_raw = len_i[int'(win_idx)*TAP_W +: TAP_W];
        len_win = (len_raw > TAP_W'(MAX_TAPS)) ? TAP_W'(MAX_TAPS) : len_raw;
    end

    always_comb begin
        smp_sel  = smp_i[int'(owner_q)*INPUT_WIDTH +: INPUT_WIDTH];
        coef_sel = coef_i[int'(owner_q)*COEFF_WIDTH +: COEFF_WIDTH];
        prod     = smp_sel * coef_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            owner_q   <= '0;
            len_q     <= '0;
            acc       <= '0;
            grant_o   <= '0;
            tap_idx_o <= '0;
            done_o    <= '0;
            result_o  <= '0;
            busy_o    <= 1'b0;
`ifndef MAC_SCHED_FIXED_PRIO_EN
            rr_ptr    <= '0;
`endif
        end else begin
            done_o <= '0;
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        owner_q   <= win_idx;
                        grant_o   <= win_onehot;
                        len_q     <= len_win;
                        acc       <= '0;
                        tap_idx_o <= '0;
                        busy_o    <= 1'b1;
                        state     <= (len_win == '0) ? S_DONE : S_MAC;
`ifndef MAC_SCHED_FIXED_PRIO_EN
                        rr_ptr    <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
                    end
                end
                S_MAC: begin
                    acc <= acc + {{TAP_W{prod[PROD_W-1]}}, prod};
                    // Index parks on the last tap rather than wrapping past the burst.
                    if (tap_idx_o == len_q - 1'b1)
                        state <= S_DONE;
                    else
                        tap_idx_o <= tap_idx_o + 1'b1;
                end
                S_DONE: begin
                    result_o <= acc;
                    done_o   <= grant_o;
                    grant_o  <= '0;
                    busy_o   <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
